// File: rtl/pipe_ctrl.sv
// Pipeline control for the in-order core: per-stage valid bits, register load enables,
// PC hold/redirect strobes and the cycle / retired-instruction counters.
module pipe_ctrl #(
    parameter int NSTAGES  = 5,
    parameter int EX_STAGE = 2,
    parameter int CNT_W    = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_stall,
    input  logic               d_stall,
    input  logic               load_use,
    input  logic               redirect,
    input  logic               flush_all,
    output logic [NSTAGES-1:0] en,
    output logic [NSTAGES-1:0] vld,
    output logic               pc_hold,
    output logic               redir_take,
    output logic               commit,
    output logic               mem_resume,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
);

    logic [NSTAGES-1:0] vld_nxt;
    logic [NSTAGES-1:0] vld_shift;
    logic               d_stall_q;

    assign vld_shift  = {vld[NSTAGES-2:0], 1'b1};
    assign commit     = vld[NSTAGES-1];
    assign mem_resume = d_stall_q & ~d_stall;

    // Fixed priority: d_stall > flush_all > redirect > load_use > i_stall.
    always_comb begin
        en         = '1;
        pc_hold    = 1'b0;
        redir_take = 1'b0;
        vld_nxt    = vld_shift;
        if (d_stall) begin
            // Drop the retiring slot so a frozen instruction commits only once.
            en                   = '0;
            pc_hold              = 1'b1;
            vld_nxt              = vld;
            vld_nxt[NSTAGES-1]   = 1'b0;
        end else if (flush_all) begin
            vld_nxt = '0;
        end else if (redirect) begin
            redir_take = 1'b1;
            for (int k = 0; k <= EX_STAGE; k++) begin
                vld_nxt[k] = 1'b0;
            end
        end else if (load_use) begin
            pc_hold = 1'b1;
            for (int k = 0; k < EX_STAGE; k++) begin
                en[k]      = 1'b0;
                vld_nxt[k] = vld[k];
            end
            vld_nxt[EX_STAGE] = 1'b0;
        end else if (i_stall) begin
            pc_hold    = 1'b1;
            vld_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld       <= '0;
            d_stall_q <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            vld       <= vld_nxt;
            d_stall_q <= d_stall;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            instr_cnt <= instr_cnt + CNT_W'(commit);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of input/expected-control rows, a stage-by-stage
// reference model feeding a scoreboard, plus an asynchronous mid-stall reset sequence.
module tb_pipe_ctrl;

    localparam int N = 5;
    localparam logic [N-1:0] ALL  = 5'b11111;
    localparam logic [N-1:0] NONE = 5'b00000;
    localparam logic [N-1:0] LU   = 5'b11100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic i_stall = 1'b0, d_stall = 1'b0, load_use = 1'b0, redirect = 1'b0, flush_all = 1'b0;

    logic [N-1:0] en, vld, en4, vld4;
    logic         pc_hold, redir_take, commit, mem_resume;
    logic         pc_hold4, redir_take4, commit4, mem_resume4;
    logic [63:0]  cycle_cnt, instr_cnt;
    logic [3:0]   cyc4, ins4;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGES(N), .EX_STAGE(2), .CNT_W(64)) dut (
        .clk(clk), .reset(reset), .i_stall(i_stall), .d_stall(d_stall),
        .load_use(load_use), .redirect(redirect), .flush_all(flush_all),
        .en(en), .vld(vld), .pc_hold(pc_hold), .redir_take(redir_take),
        .commit(commit), .mem_resume(mem_resume),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    pipe_ctrl #(.NSTAGES(N), .EX_STAGE(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .i_stall(i_stall), .d_stall(d_stall),
        .load_use(load_use), .redirect(redirect), .flush_all(flush_all),
        .en(en4), .vld(vld4), .pc_hold(pc_hold4), .redir_take(redir_take4),
        .commit(commit4), .mem_resume(mem_resume4),
        .cycle_cnt(cyc4), .instr_cnt(ins4)
    );

    typedef struct {
        string        name;
        logic         is, ds, lu, rd, fl;
        logic [N-1:0] en;
        logic         ph, rt;
    } vec_t;

    typedef struct {
        logic [N-1:0] en;
        logic         ph, rt, cm, mr;
        logic [N-1:0] vld;
        logic [63:0]  cyc, ins;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [N-1:0] m_vld = '0;
    logic         m_dq  = 1'b0;
    logic [63:0]  m_cyc = '0;
    logic [63:0]  m_ins = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic is, input logic ds,
                                input logic lu, input logic rd, input logic fl,
                                input logic [N-1:0] e, input logic ph, input logic rt,
                                input int n);
        vec_t v;
        v.name = nm; v.is = is; v.ds = ds; v.lu = lu; v.rd = rd; v.fl = fl;
        v.en = e; v.ph = ph; v.rt = rt;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Reference next-valid for a 5-deep pipe with the execute register at index 2.
    function automatic logic [N-1:0] model_next(input logic [N-1:0] v, input vec_t t);
        if (t.ds)      return {1'b0, v[3], v[2], v[1], v[0]};
        else if (t.fl) return 5'b00000;
        else if (t.rd) return {v[3], v[2], 3'b000};
        else if (t.lu) return {v[3], v[2], 1'b0, v[1], v[0]};
        else if (t.is) return {v[3], v[2], v[1], v[0], 1'b0};
        else           return {v[3], v[2], v[1], v[0], 1'b1};
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        @(negedge clk);
        i_stall = v.is; d_stall = v.ds; load_use = v.lu; redirect = v.rd; flush_all = v.fl;
        e.en  = v.en;
        e.ph  = v.ph;
        e.rt  = v.rt;
        e.cm  = m_vld[N-1];
        e.mr  = m_dq & ~v.ds;
        e.vld = model_next(m_vld, v);
        e.cyc = m_cyc + 64'd1;
        e.ins = m_ins + 64'(m_vld[N-1]);
        sb.push_back(e);
        #1;
        g = sb[0];
        chk({v.name, ".en"},         64'(en),          64'(g.en));
        chk({v.name, ".en4"},        64'(en4),         64'(g.en));
        chk({v.name, ".pc_hold"},    64'(pc_hold),     64'(g.ph));
        chk({v.name, ".redir_take"}, 64'(redir_take),  64'(g.rt));
        chk({v.name, ".commit"},     64'(commit),      64'(g.cm));
        chk({v.name, ".mem_resume"}, 64'(mem_resume),  64'(g.mr));
        @(posedge clk);
        m_vld = e.vld; m_dq = v.ds; m_cyc = e.cyc; m_ins = e.ins;
        #1;
        g = sb.pop_front();
        chk({v.name, ".vld"},       64'(vld),       64'(g.vld));
        chk({v.name, ".vld4"},      64'(vld4),      64'(g.vld));
        chk({v.name, ".cycle_cnt"}, cycle_cnt,      g.cyc);
        chk({v.name, ".instr_cnt"}, instr_cnt,      g.ins);
        chk({v.name, ".cyc4"},      64'(cyc4),      64'(g.cyc[3:0]));
        chk({v.name, ".ins4"},      64'(ins4),      64'(g.ins[3:0]));
    endtask

    initial begin
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 10);
        add("freeze",    0, 1, 0, 0, 0, NONE, 1, 0, 3);
        add("resume",    0, 0, 0, 0, 0, ALL,  0, 0, 3);
        add("loaduse",   0, 0, 1, 0, 0, LU,   1, 0, 1);
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 4);
        add("redir_lu",  0, 0, 1, 1, 0, ALL,  0, 1, 1);
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 5);
        add("redir_frz", 0, 1, 0, 1, 0, NONE, 1, 0, 2);
        add("redir_rel", 0, 0, 0, 1, 0, ALL,  0, 1, 1);
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 5);
        add("istall",    1, 0, 0, 0, 0, ALL,  1, 0, 2);
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 3);
        add("istall_lu", 1, 0, 1, 0, 0, LU,   1, 0, 1);
        add("flush",     0, 0, 1, 1, 1, ALL,  0, 0, 1);
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 6);
        add("frz_all",   1, 1, 1, 1, 1, NONE, 1, 0, 1);
        add("normal",    0, 0, 0, 0, 0, ALL,  0, 0, 3);

        #3;
        chk("rst.vld",        64'(vld),        64'd0);
        chk("rst.cycle_cnt",  cycle_cnt,       64'd0);
        chk("rst.instr_cnt",  instr_cnt,       64'd0);
        chk("rst.commit",     64'(commit),     64'd0);
        chk("rst.mem_resume", 64'(mem_resume), 64'd0);
        chk("rst.en",         64'(en),         64'(ALL));
        @(posedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i == 9) begin
                chk("fill.vld",       64'(vld), 64'(ALL));
                chk("fill.cycle_cnt", cycle_cnt, 64'd10);
                chk("fill.instr_cnt", instr_cnt, 64'd5);
            end
        end

        // Asynchronous reset arriving in the middle of a memory freeze.
        apply(vecs[10]);
        apply(vecs[11]);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst.vld",        64'(vld),        64'd0);
        chk("arst.cycle_cnt",  cycle_cnt,       64'd0);
        chk("arst.instr_cnt",  instr_cnt,       64'd0);
        chk("arst.cyc4",       64'(cyc4),       64'd0);
        chk("arst.mem_resume", 64'(mem_resume), 64'd0);
        m_vld = '0; m_dq = 1'b0; m_cyc = '0; m_ins = '0;
        @(posedge clk);
        #1;
        chk("arst_hold.vld",       64'(vld), 64'd0);
        chk("arst_hold.cycle_cnt", cycle_cnt, 64'd0);
        #2;
        d_stall = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) apply(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
